// File: rtl/stage_id.sv
// Decode stage of the turbo RV32I multi-cycle core: latches one fetched instruction,
// reads operands with RAW-hazard stalls, and holds a decode bundle for execute.
module stage_id #(
    parameter int HAZARD_WB = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_I,
    input  logic [31:0] PC_I,
    input  logic        Done_I,
    output logic        Ready_O,
    output logic [4:0]  RF_raddr1,
    output logic [4:0]  RF_raddr2,
    input  logic [31:0] RF_rdata1,
    input  logic [31:0] RF_rdata2,
    input  logic [4:0]  Dst_EX,
    input  logic [4:0]  Dst_MEM,
    input  logic [4:0]  Dst_WB,
    input  logic        Flush,
    input  logic        Ready_I,
    output logic        Done_O,
    output logic [31:0] PC_O,
    output logic [6:0]  Opcode_O,
    output logic [2:0]  Funct3_O,
    output logic        Funct7b5_O,
    output logic [4:0]  Rd_O,
    output logic [31:0] Rs1_Val_O,
    output logic [31:0] Rs2_Val_O,
    output logic [31:0] Imm_O,
    output logic        Illegal_O
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_DN   = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam bit WB_CHECK = (HAZARD_WB != 0);

    logic [1:0]  state;
    logic [31:0] ir;
    logic [31:0] pc;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic        keep_rd;
    logic        illegal;
    logic [31:0] imm;
    logic        hit1;
    logic        hit2;
    logic        hazard;

    assign Ready_O   = (state == S_IDLE) && !rst;
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign RF_raddr1 = rs1;
    assign RF_raddr2 = rs2;

    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        keep_rd = 1'b1;
        illegal = 1'b0;
        imm     = '0;
        case (ir[6:0])
            OP_LUI, OP_AUIPC: imm = {ir[31:12], 12'b0};
            OP_JAL:           imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_IMM: begin
                use1 = 1'b1;
                imm  = {{20{ir[31]}}, ir[31:20]};
            end
            OP_SYSTEM:        imm = {{20{ir[31]}}, ir[31:20]};
            OP_STORE: begin
                use1    = 1'b1;
                use2    = 1'b1;
                keep_rd = 1'b0;
                imm     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OP_BRANCH: begin
                use1    = 1'b1;
                use2    = 1'b1;
                keep_rd = 1'b0;
                imm     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_REG: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: begin
                illegal = 1'b1;
                keep_rd = 1'b0;
            end
        endcase
    end

    // x0 never conflicts, so a zero tag meaning "no destination" can never match either
    assign hit1   = (rs1 != '0) && ((rs1 == Dst_EX) || (rs1 == Dst_MEM) || (WB_CHECK && (rs1 == Dst_WB)));
    assign hit2   = (rs2 != '0) && ((rs2 == Dst_EX) || (rs2 == Dst_MEM) || (WB_CHECK && (rs2 == Dst_WB)));
    assign hazard = (use1 && hit1) || (use2 && hit2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ir         <= '0;
            pc         <= '0;
            Done_O     <= 1'b0;
            PC_O       <= '0;
            Opcode_O   <= '0;
            Funct3_O   <= '0;
            Funct7b5_O <= 1'b0;
            Rd_O       <= '0;
            Rs1_Val_O  <= '0;
            Rs2_Val_O  <= '0;
            Imm_O      <= '0;
            Illegal_O  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Done_I && !Flush) begin
                        ir    <= IR_I;
                        pc    <= PC_I;
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    if (Flush) begin
                        Done_O <= 1'b0;
                        state  <= S_IDLE;
                    end else if (!hazard) begin
                        Done_O     <= 1'b1;
                        PC_O       <= pc;
                        Opcode_O   <= ir[6:0];
                        Funct3_O   <= ir[14:12];
                        Funct7b5_O <= ir[30];
                        Rd_O       <= keep_rd ? ir[11:7] : 5'd0;
                        Rs1_Val_O  <= use1 ? RF_rdata1 : 32'd0;
                        Rs2_Val_O  <= use2 ? RF_rdata2 : 32'd0;
                        Imm_O      <= imm;
                        Illegal_O  <= illegal;
                        state      <= S_DN;
                    end
                end
                S_DN: begin
                    if (Flush || Ready_I) begin
                        Done_O <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    Done_O <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
